decap_host_sequencer: RTL and testbench
=======================================

// Module: decap_host_sequencer
// PURPOSE
// - Host-side sequencer for the decapsulation core: takes one word stream from the host and loads
//   the r memory (16-bit) and the k memory (8-bit) through their write ports.
// - Pulses Cmd=1 (init) and Cmd=2 (start), then waits for Valid.
// - Reads the 8 result words via out_addr and streams {out_r,out_k} back to the host.
// - Sits between the bus/DMA wrapper and the decapsualtion instance; one job at a time.
// PARAMETERS
// - P_WIDTH      16     r word width
// - Q_DEPTH      10     r address width
// - P_WIDTH_K    8      k word width
// - Q_DEPTH_K    11     k address width
// - R_LEN        1024   r words per job
// - K_LEN        2047   k words per job
// - INIT_CYC     5      cycles Cmd is held at 1
// - TIMEOUT_CYC  2**20  max Valid wait (only with macro)
// PORTS
// - Clk        in   1          clock, rising edge
// - Reset      in   1          asynchronous, active-high
// - start      in   1          job request; sampled in IDLE only
// - in_valid   in   1          host word valid
// - in_ready   out  1          sequencer accepts word
// - in_data    in   16         r word; [7:0] used during the k phase
// - Cmd        out  2          core command: 0 nop, 1 init, 2 start
// - wr_en_r    out  1          r memory write enable
// - wr_addr_r  out  Q_DEPTH    r memory write address
// - wr_di_r    out  P_WIDTH    r memory write data
// - wr_en_k    out  1          k memory write enable
// - wr_addr_k  out  Q_DEPTH_K  k memory write address
// - wr_di_k    out  P_WIDTH_K  k memory write data
// - out_addr   out  3          core result word select
// - out_r      in   32         core result, r hash word
// - out_k      in   32         core result, k hash word
// - Valid      in   1          core done
// - res_valid  out  1          result beat valid
// - res_ready  in   1          host accepts beat
// - res_data   out  64         {out_r,out_k}
// - res_last   out  1          high on beat 7
// - busy       out  1          high in any state other than IDLE
// - err        out  1          timeout sticky flag (0 without macro)
// BEHAVIOUR
// - Reset values: all outputs 0; state IDLE; counters 0.
//   Reset asserted mid-job aborts at once; no partial state survives.
// - States and transitions:
//   - IDLE -> INIT on start.
//   - INIT: Cmd=1 for INIT_CYC cycles -> LOAD_R.
//   - LOAD_R: in_ready=1. Each in_valid&in_ready beat registers wr_en_r=1,
//     wr_addr_r=cnt, wr_di_r=in_data (1-cycle write latency).
//     cnt wraps to 0 after R_LEN-1 -> LOAD_K.
//   - LOAD_K: same handshake into the k port using in_data[7:0].
//     After beat K_LEN-1 -> START.
//   - START: Cmd=2 for exactly 1 cycle -> WAIT.
//   - WAIT: Cmd=0; on Valid -> READ.
//   - READ: drive out_addr=idx and wait 1 settle cycle, then capture
//     res_data={out_r,out_k} and raise res_valid; res_last=(idx==7).
//   - Beat handshake: on res_valid&res_ready, idx+1 and drop res_valid for the settle cycle.
//     res_data is stable while res_valid&!res_ready.
//   - After idx 7 is accepted -> IDLE.
// - Write enables are high only on the cycle after an accepted beat.
//   in_valid with no in_ready is ignored and needs no data hold.
// - start while busy is ignored. Valid seen outside WAIT is ignored.
// - Job latency excluding host stalls: INIT_CYC + R_LEN + K_LEN + 1 + core time + 16 cycles.
// CONFIGURATION
// - DECAP_SEQ_TIMEOUT_EN defined:
//   - WAIT counts cycles; reaching TIMEOUT_CYC sets sticky err and returns to IDLE
//     without a READ phase.
//   - err clears only on the next accepted start or on Reset.
// - Undefined: WAIT never exits without Valid; err is tied to 0; no counter logic.
// TESTING
// - Nominal: start; stream r[i]=i, k[i]=i&ff; core model raises Valid 500 cycles after Cmd=2.
//   Expect 1024 r writes at addr 0..1023 and 2047 k writes at 0..2046;
//   then 8 beats with res_last only on beat 7; busy=0 after.
// - Stalls: random in_valid gaps and res_ready held low 3 cycles per beat.
//   Expect identical memory images; res_data stable while stalled.
// - Command timing: check Cmd=1 for exactly 5 cycles after start;
//   Cmd=2 for exactly 1 cycle after the last k beat; Cmd=0 otherwise.
// - Reset in LOAD_K at beat 700: all outputs 0 next edge, state IDLE.
//   A fresh job then reloads from addr 0.
// - Ignored events: start pulsed during WAIT and Valid pulsed during LOAD_R.
//   Expect no state change or extra Cmd.
// - With DECAP_SEQ_TIMEOUT_EN and TIMEOUT_CYC=64, Valid never asserted:
//   err=1 at cycle 64 of WAIT, no res_valid, busy=0; err clears on the next start.

Source files
------------

// File: rtl/decap_host_sequencer.sv
// Host-side load/command/readback sequencer for the decapsulation core.
// Optional WAIT timeout with sticky err is enabled by defining DECAP_SEQ_TIMEOUT_EN.
module decap_host_sequencer #(
    parameter int unsigned P_WIDTH   = 16,
    parameter int unsigned Q_DEPTH   = 10,
    parameter int unsigned P_WIDTH_K = 8,
    parameter int unsigned Q_DEPTH_K = 11,
    parameter int unsigned R_LEN     = 1024,
    parameter int unsigned K_LEN     = 2047,
    parameter int unsigned INIT_CYC  = 5
`ifdef DECAP_SEQ_TIMEOUT_EN
   ,parameter int unsigned TIMEOUT_CYC = 2**20
`endif
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P_WIDTH-1:0]   in_data,
    output logic [1:0]           Cmd,
    output logic                 wr_en_r,
    output logic [Q_DEPTH-1:0]   wr_addr_r,
    output logic [P_WIDTH-1:0]   wr_di_r,
    output logic                 wr_en_k,
    output logic [Q_DEPTH_K-1:0] wr_addr_k,
    output logic [P_WIDTH_K-1:0] wr_di_k,
    output logic [2:0]           out_addr,
    input  logic [31:0]          out_r,
    input  logic [31:0]          out_k,
    input  logic                 Valid,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [63:0]          res_data,
    output logic                 res_last,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned W_AK = (Q_DEPTH_K > Q_DEPTH) ? Q_DEPTH_K : Q_DEPTH;
    localparam int unsigned W_IC = $clog2(INIT_CYC + 1);
    localparam int unsigned CW   = (W_AK > W_IC) ? W_AK : W_IC;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_LOAD_R = 3'd2;
    localparam logic [2:0] S_LOAD_K = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_READ   = 3'd6;

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [1:0]           r_cmd;
    logic                 r_wr_en_r;
    logic [Q_DEPTH-1:0]   r_wr_addr_r;
    logic [P_WIDTH-1:0]   r_wr_di_r;
    logic                 r_wr_en_k;
    logic [Q_DEPTH_K-1:0] r_wr_addr_k;
    logic [P_WIDTH_K-1:0] r_wr_di_k;
    logic [2:0]           r_out_addr;
    logic                 r_res_valid;
    logic [63:0]          r_res_data;
    logic                 r_res_last;
    logic                 w_beat;

`ifdef DECAP_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;
    logic          r_err;
`endif

    assign w_beat = in_valid & in_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_wr_en_r   <= 1'b0;
            r_wr_addr_r <= '0;
            r_wr_di_r   <= '0;
            r_wr_en_k   <= 1'b0;
            r_wr_addr_k <= '0;
            r_wr_di_k   <= '0;
            r_out_addr  <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_last  <= 1'b0;
`ifdef DECAP_SEQ_TIMEOUT_EN
            r_to_cnt    <= '0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_wr_en_r <= 1'b0;
            r_wr_en_k <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_INIT;
                        r_cmd   <= 2'd1;
                        r_cnt   <= '0;
`ifdef DECAP_SEQ_TIMEOUT_EN
                        r_err   <= 1'b0;
`endif
                    end
                end
                S_INIT: begin
                    if (r_cnt == CW'(INIT_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_cmd   <= 2'd0;
                        r_state <= S_LOAD_R;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD_R: begin
                    if (w_beat) begin
                        r_wr_en_r   <= 1'b1;
                        r_wr_addr_r <= r_cnt[Q_DEPTH-1:0];
                        r_wr_di_r   <= in_data;
                        if (r_cnt == CW'(R_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_LOAD_K;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_LOAD_K: begin
                    if (w_beat) begin
                        r_wr_en_k   <= 1'b1;
                        r_wr_addr_k <= r_cnt[Q_DEPTH_K-1:0];
                        r_wr_di_k   <= in_data[P_WIDTH_K-1:0];
                        if (r_cnt == CW'(K_LEN - 1)) begin
                            r_cnt   <= '0;
                            r_cmd   <= 2'd2;
                            r_state <= S_START;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    r_cmd   <= 2'd0;
                    r_state <= S_WAIT;
`ifdef DECAP_SEQ_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (Valid) begin
                        r_state    <= S_READ;
                        r_out_addr <= '0;
                    end
`ifdef DECAP_SEQ_TIMEOUT_EN
                    else if (r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_READ: begin
                    // res_valid low marks the settle cycle after out_addr changed
                    if (!r_res_valid) begin
                        r_res_data  <= {out_r, out_k};
                        r_res_valid <= 1'b1;
                        r_res_last  <= (r_out_addr == 3'd7);
                    end else if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_res_last  <= 1'b0;
                        if (r_out_addr == 3'd7) begin
                            r_out_addr <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_out_addr <= r_out_addr + 3'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == S_LOAD_R) || (r_state == S_LOAD_K);
    assign busy      = (r_state != S_IDLE);
    assign Cmd       = r_cmd;
    assign wr_en_r   = r_wr_en_r;
    assign wr_addr_r = r_wr_addr_r;
    assign wr_di_r   = r_wr_di_r;
    assign wr_en_k   = r_wr_en_k;
    assign wr_addr_k = r_wr_addr_k;
    assign wr_di_k   = r_wr_di_k;
    assign out_addr  = r_out_addr;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_last  = r_res_last;

`ifdef DECAP_SEQ_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decap_host_sequencer.sv
// Directed bench for decap_host_sequencer: load images, command timing, readback, reset abort.
// Also exercises the DECAP_SEQ_TIMEOUT_EN timeout when that macro is defined.
module tb_decap_host_sequencer;

    localparam int R_LEN = 1024;
    localparam int K_LEN = 2047;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  Cmd;
    logic        wr_en_r;
    logic [9:0]  wr_addr_r;
    logic [15:0] wr_di_r;
    logic        wr_en_k;
    logic [10:0] wr_addr_k;
    logic [7:0]  wr_di_k;
    logic [2:0]  out_addr;
    logic [31:0] out_r;
    logic [31:0] out_k;
    logic        Valid;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        res_last;
    logic        busy;
    logic        err;

    int total = 0;
    int bad   = 0;

    // monitor state
    logic mon_clr = 1'b0;
    int nr, nk, bad_r, bad_k, n_cmd1, n_cmd2, bad_c2pos, bad_c3;

    always #5 Clk = ~Clk;

    // Core result stub: a fixed function of the selected word
    assign out_r = 32'h1000_0000 + 32'(out_addr) * 32'h101;
    assign out_k = 32'hC0DE_0000 ^ {29'd0, out_addr};

`ifdef DECAP_SEQ_TIMEOUT_EN
    decap_host_sequencer #(.TIMEOUT_CYC(64)) dut (
`else
    decap_host_sequencer dut (
`endif
        .Clk(Clk), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .Cmd(Cmd), .wr_en_r(wr_en_r), .wr_addr_r(wr_addr_r),
        .wr_di_r(wr_di_r), .wr_en_k(wr_en_k), .wr_addr_k(wr_addr_k), .wr_di_k(wr_di_k),
        .out_addr(out_addr), .out_r(out_r), .out_k(out_k), .Valid(Valid),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .busy(busy), .err(err)
    );

    always @(negedge Clk) begin
        if (mon_clr) begin
            nr = 0; nk = 0; bad_r = 0; bad_k = 0;
            n_cmd1 = 0; n_cmd2 = 0; bad_c2pos = 0; bad_c3 = 0;
        end else begin
            if (wr_en_r === 1'b1) begin
                if (wr_addr_r !== 10'(nr) || wr_di_r !== 16'(nr)) bad_r = bad_r + 1;
                nr = nr + 1;
            end
            if (wr_en_k === 1'b1) begin
                if (wr_addr_k !== 11'(nk) || wr_di_k !== 8'(nk)) bad_k = bad_k + 1;
                nk = nk + 1;
            end
            if (Cmd === 2'd1) n_cmd1 = n_cmd1 + 1;
            if (Cmd === 2'd2) begin
                n_cmd2 = n_cmd2 + 1;
                if (!(wr_en_k === 1'b1 && wr_addr_k === 11'(K_LEN - 1))) bad_c2pos = bad_c2pos + 1;
            end
            if (Cmd === 2'd3) bad_c3 = bad_c3 + 1;
        end
    end

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge Clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic stream(input bit stall, input bit vpulse, input int n);
        int w;
        for (int i = 0; i < n; i++) begin
            if (stall && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                in_data  = 16'hBAD0;
                @(negedge Clk);
            end
            in_valid = 1'b1;
            in_data  = (i < R_LEN) ? 16'(i) : {8'hEE, 8'(i - R_LEN)};
            Valid    = vpulse && (i == 10);
            if (vpulse && i == 11) begin
                chk(64'(res_valid), 64'd0, "valid_ignored_rv");
                chk(64'(in_ready), 64'd1, "valid_ignored_rdy");
            end
            w = 0;
            while (in_ready !== 1'b1 && w < 50) begin
                @(negedge Clk);
                Valid = 1'b0;
                w++;
            end
            if (w >= 50) begin
                chk(64'(in_ready), 64'd1, "in_ready_timeout");
                in_valid = 1'b0;
                return;
            end
            @(negedge Clk);
            Valid = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic read_beats(input bit stall);
        logic [63:0] exp;
        int w;
        for (int b = 0; b < 8; b++) begin
            w = 0;
            while (res_valid !== 1'b1 && w < 10) begin
                @(negedge Clk);
                w++;
            end
            exp = {32'h1000_0000 + 32'(b) * 32'h101, 32'hC0DE_0000 ^ 32'(b)};
            chk(64'(res_valid), 64'd1, "res_valid");
            chk(res_data, exp, "res_data");
            chk(64'(res_last), 64'(b == 7), "res_last");
            if (stall) begin
                repeat (3) begin
                    @(negedge Clk);
                    chk(64'(res_valid), 64'd1, "stall_valid");
                    chk(res_data, exp, "stall_data");
                end
            end
            res_ready = 1'b1;
            @(negedge Clk);
            res_ready = 1'b0;
            chk(64'(res_valid), 64'd0, "settle_valid");
        end
        chk(64'(busy), 64'd0, "busy_done");
    endtask

    task automatic run_job(input bit stall, input bit extras);
        clear_mon();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk(64'(Cmd), 64'd1, "cmd_init_first");
        chk(64'(busy), 64'd1, "busy_init");
        stream(stall, extras, R_LEN + K_LEN);
        chk(64'(Cmd), 64'd2, "cmd_start");
        for (int c = 0; c < 500; c++) begin
            start = extras && (c == 100);
            @(negedge Clk);
        end
        start = 1'b0;
        chk(64'(busy), 64'd1, "busy_wait");
        chk(64'(res_valid), 64'd0, "no_res_in_wait");
        Valid = 1'b1;
        @(negedge Clk);
        Valid = 1'b0;
        chk(64'(n_cmd1), 64'd5, "cmd1_cycles");
        chk(64'(n_cmd2), 64'd1, "cmd2_cycles");
        chk(64'(bad_c2pos), 64'd0, "cmd2_after_last_k");
        chk(64'(bad_c3), 64'd0, "cmd_illegal");
        chk(64'(nr), 64'(R_LEN), "r_write_count");
        chk(64'(bad_r), 64'd0, "r_image");
        chk(64'(nk), 64'(K_LEN), "k_write_count");
        chk(64'(bad_k), 64'd0, "k_image");
        read_beats(stall);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        Valid = 1'b0; res_ready = 1'b0;
        repeat (3) @(negedge Clk);
        chk(64'(|{in_ready, Cmd, wr_en_r, wr_addr_r, wr_di_r, wr_en_k, wr_addr_k, wr_di_k,
                  out_addr, res_valid, res_data, res_last, busy, err}), 64'd0, "reset_outputs");
        Reset = 1'b0;
        @(negedge Clk);
        chk(64'(busy), 64'd0, "idle_after_reset");

        run_job(1'b0, 1'b0);
        run_job(1'b1, 1'b1);

        // Abort in LOAD_K after 700 k beats, then a clean job from address 0
        clear_mon();
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        stream(1'b0, 1'b0, R_LEN + 700);
        #2;
        chk(64'(nk), 64'd700, "k_beats_before_reset");
        in_valid = 1'b1;
        in_data  = 16'h55AA;
        Reset = 1'b1;
        #1;
        chk(64'(|{in_ready, Cmd, wr_en_r, wr_addr_r, wr_di_r, wr_en_k, wr_addr_k, wr_di_k,
                  out_addr, res_valid, res_data, res_last, busy, err}), 64'd0, "midjob_reset_outputs");
        @(negedge Clk);
        Reset = 1'b0;
        in_valid = 1'b0;
        @(negedge Clk);
        chk(64'(busy), 64'd0, "idle_after_abort");
        chk(64'(in_ready), 64'd0, "no_ready_after_abort");
        run_job(1'b0, 1'b0);

`ifdef DECAP_SEQ_TIMEOUT_EN
        begin
            int n;
            logic rv;
            clear_mon();
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
            stream(1'b0, 1'b0, R_LEN + K_LEN);
            chk(64'(Cmd), 64'd2, "to_cmd_start");
            n = 0;
            rv = 1'b0;
            do begin
                @(negedge Clk);
                n++;
                rv = rv | res_valid;
            end while (busy === 1'b1 && n < 200);
            chk(64'(n), 64'd65, "to_wait_cycles");
            chk(64'(err), 64'd1, "to_err_set");
            chk(64'(rv), 64'd0, "to_no_res");
            chk(64'(busy), 64'd0, "to_busy");
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
            chk(64'(err), 64'd0, "to_err_clear");
            Reset = 1'b1;
            @(negedge Clk);
            Reset = 1'b0;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
